pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Fetch-stage program-counter controller. Owns the PC register and selects the next PC
//   each cycle from: sequential (+4), branch redirect, jump redirect, held redirect or
//   exception vector. Honours pipeline stalls from the hazard unit and buffers any redirect
//   that arrives during a stall. Feeds instruction memory and the IF/ID register.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value loaded on reset
//   EXC_PC    32'h0000_4180  exception entry vector (used only with PC_EXC_EN)
// PORTS
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high
//   stall       in   1   hold PC (hazard unit); 1 = no advance
//   br_taken    in   1   branch resolved taken this cycle (ID stage)
//   br_target   in   32  branch target address
//   jump        in   1   j/jal/jr redirect this cycle (ID stage)
//   jump_target in   32  jump target address
//   exc_req     in   1   exception request (present only with PC_EXC_EN)
//   pc_F        out  32  current fetch PC (registered)
//   pc4_F       out  32  pc_F + 4 (combinational, 32-bit wrap)
//   redir_pend  out  1   a redirect is buffered awaiting stall release
//   misalign    out  1   pc_F[1:0] != 2'b00 (registered with pc_F)
// BEHAVIOUR
//   - Reset (sync, active-high): pc_F=RESET_PC, redir_pend=0, misalign=0, state=RUN,
//     pending target cleared to 0. Reset overrides every other input, incl. mid-stall.
//   - State machine, 2 states:
//       RUN:  no redirect buffered. HOLD: redirect target held in pend_tgt.
//       RUN  -> HOLD on (stall & (jump|br_taken)); pend_tgt <= selected target.
//       HOLD -> RUN  on !stall; pc_F <= pend_tgt that edge.
//       HOLD stays HOLD while stall; a new jump/br_taken during HOLD overwrites pend_tgt.
//   - Next-PC priority when !stall (highest first): jump, br_taken, HOLD pend_tgt, pc4_F.
//     jump and br_taken together -> jump wins. In HOLD with !stall and new redirect,
//     new redirect wins over pend_tgt; state -> RUN.
//   - stall=1 in RUN without redirect: pc_F, misalign unchanged.
//   - Latency: redirect asserted in cycle N with stall=0 -> pc_F = target in N+1.
//     Buffered redirect -> pc_F = pend_tgt one cycle after stall deasserts.
//   - Arithmetic: all 32-bit unsigned, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//   - Targets taken verbatim (no masking); misaligned target -> misalign=1 with that pc_F.
//   - redir_pend = (state==HOLD), registered.
// CONFIGURATION
//   Macro PC_EXC_EN:
//     defined   -> exc_req port present; exc_req=1 forces pc_F<=EXC_PC next cycle,
//                  ignoring stall, jump, br_taken; clears HOLD (state->RUN, redir_pend=0).
//                  Priority: reset > exc_req > jump > br_taken > pend_tgt > +4.
//     undefined -> exc_req port and EXC_PC logic absent; priority as above minus exc_req.
// TESTING
//   1. reset 2 cycles, then stall=0 x3 -> pc_F 3000, 3004, 3008, 300C.
//   2. pc_F=3010, stall=1 x2 -> pc_F holds 3010, redir_pend=0; release -> 3014.
//   3. pc_F=3020, stall=1, br_taken=1 tgt=3100 for 1 cycle, stall 2 more cycles ->
//      redir_pend=1, pc_F=3020; stall drops -> pc_F=3100 next edge, redir_pend=0.
//   4. jump=1 tgt=3400 & br_taken=1 tgt=3200, stall=0 -> pc_F=3400; jump tgt=FFFFFFFC
//      then sequential -> 00000000; jump tgt=3002 -> misalign=1.
//   5. HOLD with pend_tgt=3100, reset=1 -> pc_F=3000, redir_pend=0, next +4 = 3004.
//   6. PC_EXC_EN: stall=1, HOLD pend 3100, exc_req=1 -> pc_F=4180, redir_pend=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: sequential/branch/jump/buffered-redirect next-PC selection.
// Optional exception vectoring is enabled by defining PC_EXC_EN (adds exc_req, EXC_PC).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
`ifdef PC_EXC_EN
  input  logic        exc_req,
`endif
  output logic [31:0] pc_F,
  output logic [31:0] pc4_F,
  output logic        redir_pend,
  output logic        misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_tgt_reg, pend_tgt_next;
  logic        misalign_reg, misalign_next;
  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        exc_take;

`ifdef PC_EXC_EN
  assign exc_take = exc_req;
`else
  assign exc_take = 1'b0;
`endif

  // jump outranks a simultaneous taken branch
  assign redirect     = jump | br_taken;
  assign redirect_tgt = jump ? jump_target : br_target;
  assign pc4_F        = pc_reg + 32'd4;

  // state register (with the PC datapath registers it controls)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      pend_tgt_reg <= 32'h0000_0000;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pend_tgt_reg <= pend_tgt_next;
      misalign_reg <= misalign_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    if (exc_take) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (stall && redirect) state_next = HOLD;
        HOLD:    if (!stall) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // datapath / output logic
  always_comb begin
    pc_next       = pc_reg;
    pend_tgt_next = pend_tgt_reg;
    if (exc_take) begin
      pc_next = EXC_PC;
    end else if (stall) begin
      // while stalled a redirect is captured, and a later one replaces it
      if (redirect) pend_tgt_next = redirect_tgt;
    end else if (redirect) begin
      pc_next = redirect_tgt;
    end else if (state_reg == HOLD) begin
      pc_next = pend_tgt_reg;
    end else begin
      pc_next = pc4_F;
    end
    misalign_next = |pc_next[1:0];
  end

  assign pc_F       = pc_reg;
  assign misalign   = misalign_reg;
  assign redir_pend = (state_reg == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; exception steps run when PC_EXC_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] pc_F;
  logic [31:0] pc4_F;
  logic        redir_pend;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
`ifdef PC_EXC_EN
    .exc_req     (exc_req),
`endif
    .pc_F        (pc_F),
    .pc4_F       (pc4_F),
    .redir_pend  (redir_pend),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  // advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_pc,
                           input logic exp_rp, input logic exp_mis);
    chk({tag, ".pc"}, pc_F, exp_pc);
    chk({tag, ".rp"}, {31'd0, redir_pend}, {31'd0, exp_rp});
    chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, exp_mis});
    $display("step %-10s pc_F=%h pc4_F=%h redir_pend=%b misalign=%b",
             tag, pc_F, pc4_F, redir_pend, misalign);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt;
  endtask

  initial begin
    reset = 1'b1; exc_req = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    chk_state("reset", 32'h0000_3000, 1'b0, 1'b0);
    chk("reset.pc4", pc4_F, 32'h0000_3004);

    // sequential fetch
    reset = 1'b0;
    tick(); chk_state("seq1", 32'h0000_3004, 1'b0, 1'b0);
    tick(); chk_state("seq2", 32'h0000_3008, 1'b0, 1'b0);
    tick(); chk_state("seq3", 32'h0000_300C, 1'b0, 1'b0);
    tick(); chk_state("seq4", 32'h0000_3010, 1'b0, 1'b0);

    // plain stall holds PC
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("stall1", 32'h0000_3010, 1'b0, 1'b0);
    tick(); chk_state("stall2", 32'h0000_3010, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("release", 32'h0000_3014, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_state("at3020", 32'h0000_3020, 1'b0, 1'b0);

    // branch during stall is buffered
    drive(1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
    tick(); chk_state("brhold", 32'h0000_3020, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("hold1", 32'h0000_3020, 1'b1, 1'b0);
    tick(); chk_state("hold2", 32'h0000_3020, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("pendapply", 32'h0000_3100, 1'b0, 1'b0);

    // later redirect during HOLD overwrites the buffered target
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3300);
    tick(); chk_state("jhold", 32'h0000_3100, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_3500, 1'b0, 32'h0);
    tick(); chk_state("overwrite", 32'h0000_3100, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("ovapply", 32'h0000_3500, 1'b0, 1'b0);

    // new redirect on release beats the buffered target
    drive(1'b1, 1'b1, 32'h0000_3600, 1'b0, 32'h0);
    tick(); chk_state("brhold2", 32'h0000_3500, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3700);
    tick(); chk_state("newwins", 32'h0000_3700, 1'b0, 1'b0);

    // jump beats branch; wrap; misaligned targets
    drive(1'b0, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_3400);
    tick(); chk_state("jprio", 32'h0000_3400, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick(); chk_state("jtop", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap.pc4", pc4_F, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("wrap", 32'h0000_0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3002);
    tick(); chk_state("misjmp", 32'h0000_3002, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("misseq", 32'h0000_3006, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
    tick(); chk_state("realign", 32'h0000_3100, 1'b0, 1'b0);

    // reset in the middle of HOLD
    drive(1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
    tick(); chk_state("brhold3", 32'h0000_3100, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    tick(); chk_state("rsthold", 32'h0000_3000, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("postrst", 32'h0000_3004, 1'b0, 1'b0);

`ifdef PC_EXC_EN
    // exception overrides stall and clears HOLD
    drive(1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
    tick(); chk_state("brhold4", 32'h0000_3004, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3800);
    exc_req = 1'b1;
    tick(); chk_state("exc", 32'h0000_4180, 1'b0, 1'b0);
    exc_req = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); chk_state("postexc", 32'h0000_4184, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
